// File: rtl/zone_light_serializer_if.sv
// Bundles the zone-result input stream and the serial LED-driver link of the
// zone light serializer so producer and serializer share one port.
interface zone_light_serializer_if #(
   parameter int IDX_W   = 9,
   parameter int LIGHT_W = 16
);
   logic               light_valid;
   logic [IDX_W-1:0]   light_index;
   logic [LIGHT_W-1:0] light;
   logic               frame_done;
   logic               sclk;
   logic               sdo;
   logic               latch;
   logic               busy;
   logic               overrun;
   logic               index_err;

   modport master (
      output light_valid, light_index, light, frame_done,
      input  sclk, sdo, latch, busy, overrun, index_err
   );

   modport slave (
      input  light_valid, light_index, light, frame_done,
      output sclk, sdo, latch, busy, overrun, index_err
   );
endinterface

// File: rtl/zone_light_serializer.sv
// Collects per-zone backlight values into a double-buffered memory and, on each
// frame boundary, shifts the finished frame MSB-first to the LED driver chain.
module zone_light_serializer #(
   parameter int ZONES   = 384,
   parameter int LIGHT_W = 16,
   parameter int IDX_W   = 9,
   parameter int CLK_DIV = 4
) (
   input logic pclk,
   input logic rst,
   zone_light_serializer_if.slave bus
);
   localparam int ZA_W  = (ZONES > 1) ? $clog2(ZONES) : 1;
   localparam int BIT_W = (LIGHT_W > 1) ? $clog2(LIGHT_W) : 1;
   localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [IDX_W:0]   ZONE_LIMIT = (IDX_W + 1)'(ZONES);
   localparam logic [IDX_W-1:0] LAST_ZONE  = IDX_W'(ZONES - 1);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(LIGHT_W - 1);
   localparam logic [DIV_W-1:0] LAST_DIV   = DIV_W'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      SHIFT,
      LATCH
   } state_t;

   state_t             state, state_n;
   logic [IDX_W-1:0]   zone, zone_n;
   logic               load_cnt, load_cnt_n;
   logic [BIT_W-1:0]   bit_cnt, bit_cnt_n;
   logic [DIV_W-1:0]   div_cnt, div_cnt_n;
   logic               phase, phase_n;
   logic [LIGHT_W-1:0] shift_reg, shift_n;
   logic [LIGHT_W-1:0] rd_data;
   logic               wr_bank, rd_bank;
   logic               index_ok;
   logic               sclk_q, sdo_q, latch_q, busy_q, overrun_q, index_err_q;

   logic [LIGHT_W-1:0] mem [2][ZONES];

   assign index_ok = ({1'b0, bus.light_index} < ZONE_LIMIT);

   // Zone memory: one write port into the accumulating bank, registered read
   // from the bank being transmitted. The banks never alias while busy.
   always_ff @(posedge pclk) begin
      if (bus.light_valid && index_ok) begin
         mem[wr_bank][bus.light_index[ZA_W-1:0]] <= bus.light;
      end
   end

   always_ff @(posedge pclk) begin
      rd_data <= mem[rd_bank][zone[ZA_W-1:0]];
   end

   // Control state plus output registers; outputs are decoded from the next
   // state so the serial link is driven straight from flops.
   always_ff @(posedge pclk) begin
      if (rst) begin
         state       <= IDLE;
         zone        <= '0;
         load_cnt    <= 1'b0;
         bit_cnt     <= '0;
         div_cnt     <= '0;
         phase       <= 1'b0;
         shift_reg   <= '0;
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
         sclk_q      <= 1'b0;
         sdo_q       <= 1'b0;
         latch_q     <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         index_err_q <= 1'b0;
      end else begin
         state       <= state_n;
         zone        <= zone_n;
         load_cnt    <= load_cnt_n;
         bit_cnt     <= bit_cnt_n;
         div_cnt     <= div_cnt_n;
         phase       <= phase_n;
         shift_reg   <= shift_n;
         if (state == IDLE && bus.frame_done) begin
            wr_bank <= ~wr_bank;
            rd_bank <= wr_bank;
         end
         sclk_q      <= (state_n == SHIFT) && phase_n;
         sdo_q       <= (state_n == SHIFT) && shift_n[LIGHT_W-1];
         latch_q     <= (state_n == LATCH);
         busy_q      <= (state_n != IDLE);
         overrun_q   <= bus.frame_done && (state != IDLE);
         index_err_q <= bus.light_valid && !index_ok;
      end
   end

   // Sequencing: two LOAD cycles cover the read latency, then each bit spends
   // CLK_DIV cycles low and CLK_DIV cycles high; the shift happens as a bit's
   // high phase ends so the next MSB appears at the start of the low phase.
   always_comb begin
      state_n    = state;
      zone_n     = zone;
      load_cnt_n = load_cnt;
      bit_cnt_n  = bit_cnt;
      div_cnt_n  = div_cnt;
      phase_n    = phase;
      shift_n    = shift_reg;
      unique case (state)
         IDLE: begin
            if (bus.frame_done) begin
               state_n    = LOAD;
               zone_n     = '0;
               load_cnt_n = 1'b0;
            end
         end
         LOAD: begin
            if (!load_cnt) begin
               load_cnt_n = 1'b1;
            end else begin
               state_n   = SHIFT;
               shift_n   = rd_data;
               bit_cnt_n = '0;
               div_cnt_n = '0;
               phase_n   = 1'b0;
            end
         end
         SHIFT: begin
            if (div_cnt != LAST_DIV) begin
               div_cnt_n = div_cnt + 1'b1;
            end else begin
               div_cnt_n = '0;
               if (!phase) begin
                  phase_n = 1'b1;
               end else begin
                  phase_n = 1'b0;
                  shift_n = shift_reg << 1;
                  if (bit_cnt != LAST_BIT) begin
                     bit_cnt_n = bit_cnt + 1'b1;
                  end else if (zone != LAST_ZONE) begin
                     zone_n     = zone + 1'b1;
                     load_cnt_n = 1'b0;
                     state_n    = LOAD;
                  end else begin
                     state_n = LATCH;
                  end
               end
            end
         end
         LATCH: begin
            if (div_cnt != LAST_DIV) begin
               div_cnt_n = div_cnt + 1'b1;
            end else begin
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.sclk      = sclk_q;
   assign bus.sdo       = sdo_q;
   assign bus.latch     = latch_q;
   assign bus.busy      = busy_q;
   assign bus.overrun   = overrun_q;
   assign bus.index_err = index_err_q;
endmodule

// File: tb/tb_zone_light_serializer.sv
// Randomized scoreboard bench for zone_light_serializer: a frame-level model
// queues expected zone words; a negedge monitor decodes the serial link.
module tb_zone_light_serializer;
   localparam int ZONES = 4;
   localparam int LW    = 16;
   localparam int IDX_W = 9;
   localparam int CD    = 2;
   localparam int FRAME = ZONES * (2 + 2 * LW * CD) + CD;

   logic pclk = 1'b0;
   logic rst;

   zone_light_serializer_if #(.IDX_W(IDX_W), .LIGHT_W(LW)) bus ();

   zone_light_serializer #(
      .ZONES(ZONES),
      .LIGHT_W(LW),
      .IDX_W(IDX_W),
      .CLK_DIV(CD)
   ) dut (
      .pclk(pclk),
      .rst(rst),
      .bus(bus)
   );

   initial forever #5 pclk = ~pclk;

   logic [LW-1:0] model_mem [2][ZONES];
   int            model_wr;
   int            busy_left;
   logic          exp_overrun;
   logic          exp_index_err;
   logic [LW-1:0] sb_q [$];
   int            n_compared;
   int            n_mismatched;
   bit            chk_en;

   int            mon_bits;
   int            mon_edges;
   logic [LW-1:0] mon_word;
   logic          prev_sclk;
   logic          prev_latch;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_compared++;
      if (act !== exp) begin
         n_mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One input cycle; the model advances on the same edge the DUT samples.
   task automatic applyStimulus(input bit v, input int idx, input logic [LW-1:0] val, input bit fd);
      int old;
      bus.light_valid = v;
      bus.light_index = idx[IDX_W-1:0];
      bus.light       = val;
      bus.frame_done  = fd;
      @(posedge pclk);
      old           = busy_left;
      exp_index_err = v && (idx >= ZONES);
      if (v && idx < ZONES) model_mem[model_wr][idx] = val;
      exp_overrun = fd && (old > 0);
      if (fd && old == 0) begin
         for (int z = 0; z < ZONES; z++) sb_q.push_back(model_mem[model_wr][z]);
         model_wr  = 1 - model_wr;
         busy_left = FRAME;
      end else if (old > 0) begin
         busy_left = old - 1;
      end
      #1;
      bus.light_valid = 1'b0;
      bus.frame_done  = 1'b0;
   endtask

   task automatic applyReset(input int n);
      bus.light_valid = 1'b0;
      bus.light_index = '0;
      bus.light       = '0;
      bus.frame_done  = 1'b0;
      rst = 1'b1;
      repeat (n) begin
         @(posedge pclk);
         busy_left     = 0;
         model_wr      = 0;
         exp_overrun   = 1'b0;
         exp_index_err = 1'b0;
         sb_q.delete();
         chk_en        = 1'b1;
      end
      #1 rst = 1'b0;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) applyStimulus(1'b0, 0, '0, 1'b0);
   endtask

   task automatic waitIdle();
      idleCycles(busy_left + 3);
   endtask

   // Monitor: per-cycle status against the model, plus serial word decode.
   always @(negedge pclk) begin
      if (chk_en) begin
         checkOutput("busy", 32'(bus.busy), 32'(busy_left > 0));
         checkOutput("overrun", 32'(bus.overrun), 32'(exp_overrun));
         checkOutput("index_err", 32'(bus.index_err), 32'(exp_index_err));
         checkOutput("latch", 32'(bus.latch), 32'(busy_left > 0 && busy_left <= CD));
         if (busy_left == 0 || busy_left <= CD) begin
            checkOutput("sclk_quiet", 32'(bus.sclk), 32'd0);
            checkOutput("sdo_quiet", 32'(bus.sdo), 32'd0);
         end
         if (rst) begin
            mon_bits  = 0;
            mon_edges = 0;
            mon_word  = '0;
         end else begin
            if (bus.sclk && !prev_sclk) begin
               mon_word = {mon_word[LW-2:0], bus.sdo};
               mon_bits++;
               mon_edges++;
               if (mon_bits == LW) begin
                  mon_bits = 0;
                  if (sb_q.size() == 0) begin
                     n_compared++;
                     n_mismatched++;
                     $display("[TB] FAIL zone_word: got unexpected word 0x%0h, expected none at %0t",
                              mon_word, $time);
                  end else begin
                     checkOutput("zone_word", 32'(mon_word), 32'(sb_q.pop_front()));
                  end
               end
            end
            if (prev_latch && !bus.latch) begin
               checkOutput("sclk_edges", 32'(mon_edges), 32'(ZONES * LW));
               mon_edges = 0;
            end
         end
         prev_sclk  = bus.sclk;
         prev_latch = bus.latch;
      end
   end

   initial begin
      int r;
      n_compared   = 0;
      n_mismatched = 0;
      chk_en       = 1'b0;
      busy_left    = 0;
      model_wr     = 0;
      mon_bits     = 0;
      mon_edges    = 0;
      mon_word     = '0;
      prev_sclk    = 1'b0;
      prev_latch   = 1'b0;
      applyReset(3);

      // Basic frame, then refill the other bank while it is on the wire.
      applyStimulus(1'b1, 0, 16'h8001, 1'b0);
      applyStimulus(1'b1, 1, 16'h00FF, 1'b0);
      applyStimulus(1'b1, 2, 16'hFFFF, 1'b0);
      applyStimulus(1'b1, 3, 16'h1234, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1);
      idleCycles(20);
      for (int z = 0; z < ZONES; z++) applyStimulus(1'b1, z, 16'hAAAA, 1'b0);
      waitIdle();

      // Second frame with an overrun ten cycles in.
      applyStimulus(1'b0, 0, '0, 1'b1);
      idleCycles(10);
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitIdle();

      // Write coinciding with the frame boundary belongs to the sent frame.
      applyStimulus(1'b1, 3, 16'h5A5A, 1'b1);
      waitIdle();

      // Out-of-range index must not disturb any zone.
      applyStimulus(1'b1, 4, 16'hDEAD, 1'b0);
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitIdle();

      // Reset during zone 2, bit 5, then a clean frame.
      applyStimulus(1'b0, 0, '0, 1'b1);
      idleCycles(156);
      applyReset(1);
      idleCycles(3);
      applyStimulus(1'b0, 0, '0, 1'b1);
      waitIdle();

      // Randomized traffic with occasional bad indices and stray frame_done.
      for (int f = 0; f < 8; f++) begin
         int len;
         len = $urandom_range(150, 400);
         for (int c = 0; c < len; c++) begin
            r = $urandom_range(0, 99);
            if (r < 30)
               applyStimulus(1'b1, $urandom_range(0, ZONES - 1), 16'($urandom), 1'b0);
            else if (r < 33)
               applyStimulus(1'b1, $urandom_range(ZONES, 511), 16'($urandom), 1'b0);
            else if (r < 34)
               applyStimulus(1'b0, 0, '0, 1'b1);
            else
               applyStimulus(1'b0, 0, '0, 1'b0);
         end
         applyStimulus(($urandom_range(0, 1) == 1), $urandom_range(0, ZONES - 1), 16'($urandom), 1'b1);
         idleCycles($urandom_range(0, 300));
      end
      waitIdle();
      idleCycles(5);
      checkOutput("sb_drain", 32'(sb_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule
